// File: rtl/key_event_decode_pkg.sv
// Shared constants for the key event classifier: FSM encoding, counter widths
// and default 50 MHz timing.
package key_event_decode_pkg;

    localparam int TMR_W = 32;
    localparam int CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BURST1 = 2'd1;
    localparam logic [1:0] ST_WAIT2  = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam int GAP_MAX_DEF  = 1500000;
    localparam int DBL_MAX_DEF  = 15000000;
    localparam int LONG_CNT_DEF = 50;

    typedef struct packed {
        logic lng;
        logic dbl;
        logic single;
    } evt_flags_t;

endpackage

// File: rtl/key_evt_timer.sv
// Saturating pulse-free cycle counter; strobes timeout in the cycle the count
// reaches limit, and only once per run since the count then sits above it.
module key_evt_timer
    import key_event_decode_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [TMR_W-1:0] limit,
    output logic             timeout
);

    logic [TMR_W-1:0] count;
    logic             at_max;

    assign at_max  = &count;
    assign timeout = en && !clear && !at_max && (count == limit - TMR_W'(1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en && !at_max)
            count <= count + TMR_W'(1);
    end

endmodule

// File: rtl/key_event_decode.sv
// Classifies debounced key pulses into single click, double click or long press
// and emits one registered 1-cycle flag per event.
module key_event_decode
    import key_event_decode_pkg::*;
#(
    parameter int GAP_MAX  = GAP_MAX_DEF,
    parameter int DBL_MAX  = DBL_MAX_DEF,
    parameter int LONG_CNT = LONG_CNT_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_flag,
    output logic single_flag,
    output logic double_flag,
    output logic long_flag,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CNT);

    logic             key_d;
    logic             pulse;
    logic             gap_to;
    logic             win_to;
    logic             enter_wait2;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    evt_flags_t       evt, flags_q;

    assign pulse       = key_flag & ~key_d;
    assign enter_wait2 = (state == ST_BURST1) && gap_to;
    assign cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);

    key_evt_timer u_gap (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clear   (pulse),
        .en      (~pulse),
        .limit   (TMR_W'(GAP_MAX)),
        .timeout (gap_to)
    );

    // Disabled on pulse cycles so a coincident press beats the window timeout.
    key_evt_timer u_win (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clear   (enter_wait2),
        .en      (~pulse),
        .limit   (TMR_W'(DBL_MAX)),
        .timeout (win_to)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        evt       = '0;
        case (state)
            ST_IDLE: begin
                if (pulse) begin
                    state_nxt = ST_BURST1;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_BURST1: begin
                if (pulse) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == LONG_C) begin
                        evt.lng   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (gap_to) begin
                    state_nxt = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (pulse) begin
                    evt.dbl   = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (win_to) begin
                    evt.single = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                if (!pulse && gap_to)
                    state_nxt = ST_IDLE;
            end
        endcase
    end

    // busy also covers the flag cycle after returning to IDLE.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            key_d   <= 1'b0;
            state   <= ST_IDLE;
            cnt     <= '0;
            flags_q <= '0;
            busy    <= 1'b0;
        end else begin
            key_d   <= key_flag;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            flags_q <= evt;
            busy    <= (state != ST_IDLE) || (state_nxt != ST_IDLE);
        end
    end

    assign single_flag = flags_q.single;
    assign double_flag = flags_q.dbl;
    assign long_flag   = flags_q.lng;

endmodule

// File: tb/tb_key_event_decode.sv
// Scoreboard bench for key_event_decode with short timing parameters.
module tb_key_event_decode;

    localparam int GAP     = 8;
    localparam int DBL     = 20;
    localparam int LNG     = 4;
    localparam int SCN_LEN = 200;

    localparam logic [2:0] K_SINGLE = 3'b001;
    localparam logic [2:0] K_DOUBLE = 3'b010;
    localparam logic [2:0] K_LONG   = 3'b100;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic key_flag = 1'b0;
    logic single_flag, double_flag, long_flag, busy;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   base   = 0;
    bit   mon_en = 1'b0;
    bit   pat[SCN_LEN];
    bit   exp_busy[SCN_LEN];
    int   rst_lo = -1;
    int   rst_hi = -1;

    int         m_rel;
    logic [2:0] m_f;
    exp_t       m_e;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    key_event_decode #(
        .GAP_MAX  (GAP),
        .DBL_MAX  (DBL),
        .LONG_CNT (LNG)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .key_flag    (key_flag),
        .single_flag (single_flag),
        .double_flag (double_flag),
        .long_flag   (long_flag),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", tag, got, exp, cyc - base);
        end
    endtask

    always @(negedge sys_clk) begin
        if (mon_en) begin
            m_rel = cyc - base;
            m_f   = {long_flag, double_flag, single_flag};
            if (m_rel >= 0 && m_rel < SCN_LEN)
                chk("busy", {31'd0, busy}, {31'd0, exp_busy[m_rel]});
            chk("onehot", {31'd0, ($countones(m_f) <= 1)}, 32'd1);
            if (m_f != 3'b000) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_flag", {29'd0, m_f}, 32'd0);
                end else begin
                    m_e = sb_q.pop_front();
                    chk("flag_kind", {29'd0, m_f}, {29'd0, m_e.kind});
                    chk("flag_cycle", m_rel, m_e.cyc);
                end
            end
        end
    end

    task automatic clr_scn();
        for (int i = 0; i < SCN_LEN; i++) begin
            pat[i]      = 1'b0;
            exp_busy[i] = 1'b0;
        end
        rst_lo = -1;
        rst_hi = -1;
        sb_q.delete();
    endtask

    task automatic set_busy(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_busy[i] = 1'b1;
    endtask

    task automatic push_exp(input int c, input logic [2:0] k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        sb_q.push_back(e);
    endtask

    task automatic run_scn(input string name);
        @(posedge sys_clk);
        #1;
        base   = cyc;
        mon_en = 1'b1;
        for (int r = 0; r < SCN_LEN; r++) begin
            key_flag = pat[r];
            rst_n    = !(r >= rst_lo && r <= rst_hi);
            @(posedge sys_clk);
            #1;
        end
        mon_en = 1'b0;
        key_flag = 1'b0;
        rst_n    = 1'b1;
        chk({name, "_pending"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_single", {31'd0, single_flag}, 32'd0);
        chk("rst_double", {31'd0, double_flag}, 32'd0);
        chk("rst_long",   {31'd0, long_flag},   32'd0);
        chk("rst_busy",   {31'd0, busy},        32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);

        clr_scn();
        pat[100] = 1'b1;
        push_exp(129, K_SINGLE);
        set_busy(101, 129);
        run_scn("single");

        clr_scn();
        pat[100] = 1'b1; pat[115] = 1'b1; pat[118] = 1'b1; pat[121] = 1'b1;
        push_exp(116, K_DOUBLE);
        set_busy(101, 130);
        run_scn("double");

        clr_scn();
        for (int c = 100; c <= 140; c += 4) pat[c] = 1'b1;
        push_exp(113, K_LONG);
        set_busy(101, 149);
        run_scn("long");

        clr_scn();
        pat[100] = 1'b1; pat[101] = 1'b1; pat[102] = 1'b1;
        push_exp(129, K_SINGLE);
        set_busy(101, 129);
        run_scn("stretch");

        clr_scn();
        pat[100] = 1'b1; pat[128] = 1'b1;
        push_exp(129, K_DOUBLE);
        set_busy(101, 137);
        run_scn("coincide");

        clr_scn();
        pat[100] = 1'b1; pat[104] = 1'b1; pat[120] = 1'b1;
        rst_lo = 106;
        rst_hi = 108;
        push_exp(149, K_SINGLE);
        set_busy(101, 105);
        set_busy(121, 149);
        run_scn("reset_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
